// File: rtl/stopwatch_pkg.sv
// Shared definitions for the BCD stopwatch: FSM encoding, BCD digit width and
// the per-position digit limits.
package stopwatch_pkg;

   localparam int BCD_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [BCD_W-1:0] TENTHS_MAX    = 4'd9;
   localparam logic [BCD_W-1:0] SEC_UNITS_MAX = 4'd9;
   localparam logic [BCD_W-1:0] SEC_TENS_MAX  = 4'd5;
   localparam logic [BCD_W-1:0] MIN_DIGIT_MAX = 4'd9;

   // Digit 0 is tenths; every position from 3 upward is a minute digit.
   function automatic logic [BCD_W-1:0] digit_max(input int idx);
      case (idx)
         0:       return TENTHS_MAX;
         1:       return SEC_UNITS_MAX;
         2:       return SEC_TENS_MAX;
         default: return MIN_DIGIT_MAX;
      endcase
   endfunction

endpackage

// File: rtl/stopwatch_tick.sv
// Prescaler: one-cycle tick every TICK_DIV enabled cycles; dropping en returns
// the count to zero so the next enabled period starts from scratch.
module stopwatch_tick #(
   parameter int TICK_DIV = 5_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam int CW = $clog2(TICK_DIV);
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if (!en || cnt_q == LAST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/stopwatch_gen.sv
// BCD stopwatch / countdown timer with preset, clear, lap capture and a
// limit-detect pulse; stops or rolls over at the limit depending on WRAP.
module stopwatch_gen
   import stopwatch_pkg::*;
#(
   parameter  int TICK_DIV   = 5_000_000,
   parameter  int MIN_DIGITS = 1,
   parameter  int WRAP       = 0,
   localparam int ND         = MIN_DIGITS + 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              go,
   input  logic              up,
   input  logic              clr,
   input  logic              load,
   input  logic [4*ND-1:0]   load_val,
   input  logic              lap,
   output logic [4*ND-1:0]   digits,
   output logic [4*ND-1:0]   lap_digits,
   output logic              lap_valid,
   output logic              done,
   output logic              running
);

   localparam int W       = BCD_W * ND;
   localparam bit WRAP_EN = (WRAP != 0);

   state_t          state_q;
   logic [W-1:0]    digits_q;
   logic [W-1:0]    lap_digits_q;
   logic            lap_valid_q;
   logic            done_q;
   logic            running_q;

   logic            tick;
   logic            tick_en;
   logic [ND-1:0]   at_max;
   logic [ND-1:0]   at_zero;
   logic [W-1:0]    inc_d;
   logic [W-1:0]    dec_d;
   logic [W-1:0]    clamp_d;
   logic [W-1:0]    step_d;
   logic            at_limit;
   logic            hit_stop;

   // clr/load also drop the enable, which restarts the prescaler period.
   assign tick_en = (state_q == ST_RUN) && !clr && !load;

   stopwatch_tick #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .en   (tick_en),
      .tick (tick)
   );

   for (genvar gi = 0; gi < ND; gi++) begin : g_digit
      localparam logic [BCD_W-1:0] LIM = digit_max(gi);

      logic [BCD_W-1:0] cur;
      logic [BCD_W-1:0] pre;
      logic             carry_in;
      logic             borrow_in;

      assign cur         = digits_q[gi*BCD_W +: BCD_W];
      assign pre         = load_val[gi*BCD_W +: BCD_W];
      assign at_max[gi]  = (cur >= LIM);
      assign at_zero[gi] = (cur == '0);

      // A digit moves only when every lower digit sits at its limit.
      if (gi == 0) begin : g_lsd
         assign carry_in  = 1'b1;
         assign borrow_in = 1'b1;
      end else begin : g_upper
         assign carry_in  = &at_max[gi-1:0];
         assign borrow_in = &at_zero[gi-1:0];
      end

      assign inc_d[gi*BCD_W +: BCD_W]   = !carry_in  ? cur : (at_max[gi]  ? '0  : cur + 1'b1);
      assign dec_d[gi*BCD_W +: BCD_W]   = !borrow_in ? cur : (at_zero[gi] ? LIM : cur - 1'b1);
      assign clamp_d[gi*BCD_W +: BCD_W] = (pre > LIM) ? LIM : pre;
   end

   assign step_d   = up ? inc_d : dec_d;
   assign at_limit = up ? (&at_max) : (&at_zero);
   assign hit_stop = tick && at_limit && !WRAP_EN;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         digits_q     <= '0;
         lap_digits_q <= '0;
         lap_valid_q  <= 1'b0;
         done_q       <= 1'b0;
         running_q    <= 1'b0;
      end else begin
         lap_valid_q <= lap;
         done_q      <= 1'b0;
         if (lap) begin
            lap_digits_q <= digits_q;
         end

         if (clr) begin
            digits_q  <= '0;
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
         end else if (load) begin
            digits_q <= clamp_d;
            if (state_q == ST_DONE) begin
               state_q   <= ST_IDLE;
               running_q <= 1'b0;
            end
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (go) begin
                     state_q   <= ST_RUN;
                     running_q <= 1'b1;
                  end
               end
               ST_RUN: begin
                  if (tick) begin
                     done_q <= at_limit;
                     if (!hit_stop) begin
                        digits_q <= step_d;
                     end
                  end
                  if (hit_stop) begin
                     state_q   <= ST_DONE;
                     running_q <= 1'b0;
                  end else if (!go) begin
                     state_q   <= ST_IDLE;
                     running_q <= 1'b0;
                  end
               end
               ST_DONE: begin
                  if (!go) begin
                     state_q   <= ST_IDLE;
                     running_q <= 1'b0;
                  end
               end
               default: begin
                  state_q   <= ST_IDLE;
                  running_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign digits     = digits_q;
   assign lap_digits = lap_digits_q;
   assign lap_valid  = lap_valid_q;
   assign done       = done_q;
   assign running    = running_q;

endmodule

// File: doc/stopwatch_gen.md
STOPWATCH_GEN -- requirements
Module: stopwatch_gen

Interface
REQ-001 SHALL have parameter TICK_DIV, default 5_000_000: clock cycles per count step (1/10 s at 50 MHz); legal range >= 2.
REQ-002 SHALL have parameter MIN_DIGITS, default 1: number of BCD minute digits; legal range 1..3.
REQ-003 SHALL have parameter WRAP, default 0: 0 = stop at the limit, 1 = roll over at the limit.
REQ-004 SHALL define localparam ND = MIN_DIGITS+3 as the total digit count.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port go, input, 1 bit: level; counting SHALL run while go is high.
REQ-008 SHALL have port up, input, 1 bit: level; 1 = count up, 0 = count down.
REQ-009 SHALL have port clr, input, 1 bit: synchronous clear pulse.
REQ-010 SHALL have port load, input, 1 bit: synchronous preset pulse.
REQ-011 SHALL have port load_val, input, 4*ND bits: BCD preset value.
REQ-012 SHALL have port lap, input, 1 bit: lap-capture pulse.
REQ-013 SHALL have port digits, output, 4*ND bits: BCD time; [3:0] = tenths, [7:4] = seconds units, [11:8] = seconds tens, and the minute digits above.
REQ-014 SHALL have port lap_digits, output, 4*ND bits: captured lap value.
REQ-015 SHALL have port lap_valid, output, 1 bit: one-cycle pulse that marks a new capture.
REQ-016 SHALL have port done, output, 1 bit: one-cycle pulse at a limit.
REQ-017 SHALL have port running, output, 1 bit: high in state RUN.

Function
REQ-018 SHALL implement a 3-state FSM: IDLE, RUN, DONE.
REQ-019 SHALL make these FSM transitions: IDLE->RUN when go=1; RUN->IDLE when go=0; RUN->DONE on a limit with WRAP=0; DONE->IDLE when go=0.
REQ-020 SHALL generate the count step from a prescaler: tick is high for one cycle every TICK_DIV cycles while in RUN.
REQ-021 SHALL hold the prescaler at 0 outside RUN, so the first step occurs exactly TICK_DIV cycles after entering RUN.
REQ-022 SHALL update digits at the clock edge that ends the tick cycle (latency 1).
REQ-023 SHALL apply these digit limits: tenths 0-9, seconds units 0-9, seconds tens 0-5, each minute digit 0-9.
REQ-024 SHALL propagate carry and borrow only through digits that are at their limit.
REQ-025 SHALL define the up limit as all digits at their maximum, e.g. 9:59.9 for MIN_DIGITS=1.
REQ-026 SHALL define the down limit as all digits at 0.
REQ-027 SHALL, on a tick at a limit with WRAP=0: hold digits, assert done, and go to DONE.
REQ-028 SHALL, on a tick at a limit with WRAP=1: roll to 0 (up) or to the maximum (down), assert done, and stay in RUN.
REQ-029 SHALL allow up to change while in RUN; the next tick SHALL use the new direction, and the prescaler SHALL NOT be cleared.
REQ-030 SHALL give simultaneous controls this priority: clr > load > tick.
REQ-031 SHALL make clr zero digits, clear the prescaler, and force IDLE.
REQ-032 SHALL make load copy load_val into digits, clamping each digit to its own limit, clear the prescaler, and leave the state unchanged (DONE goes to IDLE).
REQ-033 SHALL capture digits into lap_digits on lap and pulse lap_valid the next cycle.
REQ-034 SHALL capture the pre-update value when lap coincides with a tick.
REQ-035 SHALL keep lap capture working in every state.
REQ-036 SHALL NOT let lap alter the count.
REQ-037 SHALL NOT assert done in the same cycle as clr or load.

Reset
REQ-038 SHALL, while rst=0, asynchronously force: state IDLE, prescaler 0, digits 0, lap_digits 0, lap_valid 0, done 0, running 0.
REQ-039 SHALL release reset synchronously to clk.
REQ-040 SHALL make a reset during RUN discard any pending tick; after release the block SHALL wait for go.

Structure
REQ-041 SHALL place the FSM state encoding, the per-digit limit constants and the BCD digit width in a shared package, stopwatch_pkg.
REQ-042 SHALL implement the prescaler as sub-module stopwatch_tick, with parameter TICK_DIV, inputs clk, rst and en, and output tick.
REQ-043 SHALL implement the digit chain as generate-loop combinational logic driving a single register vector.

Verification
Each scenario runs with TICK_DIV=4 and MIN_DIGITS=1 unless stated.
REQ-044 SHALL cover carry: load 0:59.8, go=1, up=1 -> 0:59.9 after 4 cycles, then 1:00.0 after 4 more.
REQ-045 SHALL cover the up limit with WRAP=0: load 9:59.8, go=1, up=1 -> 9:59.9, then done pulses once after the next tick, digits hold at 9:59.9, state DONE; go=0 -> IDLE.
REQ-046 SHALL cover the down limit with WRAP=1: load 0:00.1, up=0, go=1 -> 0:00.0, then 9:59.9 with done pulsed and running still 1.
REQ-047 SHALL cover load clamping: load_val 0:7A.F -> digits 0:59.9.
REQ-048 SHALL cover simultaneous events: clr+load+lap on a tick cycle -> digits 0:00.0, lap_digits equal the pre-clear value, lap_valid pulses 1 cycle later, done stays 0.
REQ-049 SHALL cover reset mid-operation: rst=0 asserted mid-RUN at 3:21.4 -> all outputs 0 immediately without a clock edge; after release, go=1 -> first step 4 cycles later gives 0:00.1.
